// File: rtl/dbg_loader_pkg.sv
// Shared definitions for the UART debug loader: command/response bytes and frame states.
package dbg_loader_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_HALT  = 8'h48;
  localparam logic [7:0] CMD_GO    = 8'h47;

  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dbg_loader_timeout.sv
// Inter-byte idle counter: expires after TIMEOUT_CYCLES idle cycles while a frame is open.
module dbg_loader_timeout
  import dbg_loader_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt <= '0;
    end else if (clr || !run) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A byte arriving in the expiry cycle suppresses the expiry.
  assign expired = run && !clr && (cnt == LAST);

endmodule

// File: rtl/dbg_uart_loader.sv
// UART-framed loader that writes words through the SoC debug memory port and controls CPU reset.
module dbg_uart_loader
  import dbg_loader_pkg::*;
#(
  parameter int WR_CYCLES      = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int BOOT_HALTED    = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        cpu_n_reset,
  output logic        dbg_mem_op,
  output logic [3:0]  dbg_wren,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do
);

  localparam int WW = $clog2(WR_CYCLES + 1);
  localparam logic [WW-1:0] WR_LAST = WW'(WR_CYCLES - 1);
  localparam logic RUN_AT_BOOT = (BOOT_HALTED == 0);

  state_t        state;
  logic [1:0]    idx;
  logic [31:0]   addr_sr;
  logic [31:0]   data_sr;
  logic [WW-1:0] wcnt;
  logic          tmo_run;
  logic          tmo_expired;

  assign tmo_run = (state == ST_ADDR) || (state == ST_DATA);

  dbg_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .n_reset(n_reset),
    .run    (tmo_run),
    .clr    (rx_valid),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      addr_sr     <= '0;
      data_sr     <= '0;
      wcnt        <= '0;
      cpu_n_reset <= RUN_AT_BOOT;
      dbg_mem_op  <= 1'b0;
      dbg_wren    <= 4'h0;
      dbg_adr     <= '0;
      dbg_do      <= '0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            idx <= '0;
            case (rx_data)
              CMD_WRITE: state <= ST_ADDR;
              CMD_HALT: begin
                cpu_n_reset <= 1'b0;
                tx_data     <= RSP_ACK;
                tx_valid    <= 1'b1;
                state       <= ST_RESP;
              end
              CMD_GO: begin
                cpu_n_reset <= 1'b1;
                tx_data     <= RSP_ACK;
                tx_valid    <= 1'b1;
                state       <= ST_RESP;
              end
              default: begin
                tx_data  <= RSP_NAK;
                tx_valid <= 1'b1;
                state    <= ST_RESP;
              end
            endcase
          end
        end

        ST_ADDR: begin
          if (rx_valid) begin
            addr_sr <= {rx_data, addr_sr[31:8]};
            idx     <= idx + 1'b1;
            if (idx == 2'd3) state <= ST_DATA;
          end else if (tmo_expired) begin
            state <= ST_IDLE;
          end
        end

        ST_DATA: begin
          if (rx_valid) begin
            data_sr <= {rx_data, data_sr[31:8]};
            idx     <= idx + 1'b1;
            if (idx == 2'd3) begin
              // Only aligned writes into a halted CPU reach the memory port.
              if ((addr_sr[1:0] != 2'b00) || cpu_n_reset) begin
                tx_data  <= RSP_NAK;
                tx_valid <= 1'b1;
                state    <= ST_RESP;
              end else begin
                dbg_adr    <= addr_sr;
                dbg_do     <= {rx_data, data_sr[31:8]};
                dbg_mem_op <= 1'b1;
                dbg_wren   <= 4'hF;
                wcnt       <= '0;
                state      <= ST_WRITE;
              end
            end
          end else if (tmo_expired) begin
            state <= ST_IDLE;
          end
        end

        ST_WRITE: begin
          if (wcnt == WR_LAST) begin
            dbg_mem_op <= 1'b0;
            dbg_wren   <= 4'h0;
            tx_data    <= RSP_ACK;
            tx_valid   <= 1'b1;
            state      <= ST_RESP;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end

        ST_RESP: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_uart_loader.sv
// Scoreboard bench for dbg_uart_loader: frames are modelled at the command level, responses and writes are monitored.
module tb_dbg_uart_loader;
  import dbg_loader_pkg::*;

  localparam int WR_CYC = 4;
  localparam int TMO    = 64;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        cpu_n_reset;
  logic        dbg_mem_op;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_do;

  dbg_uart_loader #(
    .WR_CYCLES     (WR_CYC),
    .TIMEOUT_CYCLES(TMO),
    .BOOT_HALTED   (1)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .cpu_n_reset(cpu_n_reset),
    .dbg_mem_op (dbg_mem_op),
    .dbg_wren   (dbg_wren),
    .dbg_adr    (dbg_adr),
    .dbg_do     (dbg_do)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rsp;
    logic       cpu;
  } rsp_t;
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   model_run = 1'b0;
  bit   hold_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      tx_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Response monitor
  logic [7:0] held;
  bit         have_held = 1'b0;
  bit         was_hs = 1'b0;
  rsp_t       rexp;
  always @(negedge clk) begin
    if (!n_reset) begin
      have_held = 1'b0;
      was_hs    = 1'b0;
    end else begin
      if (was_hs) check("tx_valid_drop", {31'd0, tx_valid}, 32'd0);
      was_hs = 1'b0;
      if (tx_valid) begin
        if (have_held) check("tx_data_stable", {24'd0, tx_data}, {24'd0, held});
        held      = tx_data;
        have_held = 1'b1;
        if (tx_ready) begin
          if (rsp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_rsp: got 0x%0h with none expected at %0t", tx_data, $time);
          end else begin
            rexp = rsp_q.pop_front();
            check("rsp_byte", {24'd0, tx_data}, {24'd0, rexp.rsp});
            check("rsp_cpu_n_reset", {31'd0, cpu_n_reset}, {31'd0, rexp.cpu});
          end
          have_held = 1'b0;
          was_hs    = 1'b1;
        end
      end
    end
  end

  // Memory write monitor
  int  run_len = 0;
  wr_t wexp;
  always @(negedge clk) begin
    if (!n_reset) begin
      run_len = 0;
    end else if (dbg_mem_op) begin
      check("wren_on", {28'd0, dbg_wren}, 32'hF);
      if (run_len == 0) begin
        if (wr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_write: adr 0x%0h do 0x%0h with none expected", dbg_adr, dbg_do);
          wexp.adr = dbg_adr;
          wexp.dat = dbg_do;
        end else begin
          wexp = wr_q.pop_front();
          check("dbg_adr", dbg_adr, wexp.adr);
          check("dbg_do", dbg_do, wexp.dat);
        end
      end else begin
        check("adr_stable", dbg_adr, wexp.adr);
        check("do_stable", dbg_do, wexp.dat);
      end
      run_len++;
    end else begin
      check("wren_off", {28'd0, dbg_wren}, 32'd0);
      if (run_len != 0) begin
        check("wr_cycles", run_len, WR_CYC);
        check("ack_after_write", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, RSP_ACK});
        run_len = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  // Reference model: decide response and write from the command rules, then send.
  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat,
                            input int fixed_gap);
    rsp_t r;
    wr_t  w;
    bit   wr_ok;
    wr_ok = 1'b0;
    if (cmd == 8'h57) begin
      if ((adr % 4) == 0 && !model_run) begin
        wr_ok = 1'b1;
        r.rsp = 8'h06;
      end else begin
        r.rsp = 8'h15;
      end
    end else if (cmd == 8'h48) begin
      model_run = 1'b0;
      r.rsp     = 8'h06;
    end else if (cmd == 8'h47) begin
      model_run = 1'b1;
      r.rsp     = 8'h06;
    end else begin
      r.rsp = 8'h15;
    end
    r.cpu = model_run;
    rsp_q.push_back(r);
    if (wr_ok) begin
      w.adr = adr;
      w.dat = dat;
      wr_q.push_back(w);
    end
    send_byte(cmd, 0);
    if (cmd != 8'h57) begin
      check("cpu_after_cmd", {31'd0, cpu_n_reset}, {31'd0, model_run});
      check("rsp_latency", {31'd0, tx_valid}, 32'd1);
    end else begin
      for (int i = 0; i < 4; i++)
        send_byte(adr[8*i +: 8], (fixed_gap >= 0) ? fixed_gap : $urandom_range(0, 2));
      for (int i = 0; i < 4; i++)
        send_byte(dat[8*i +: 8], (fixed_gap >= 0) ? fixed_gap : $urandom_range(0, 2));
      check("op_latency", {31'd0, dbg_mem_op}, {31'd0, wr_ok});
      if (!wr_ok) check("nak_latency", {31'd0, tx_valid}, 32'd1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || wr_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_rsp", rsp_q.size(), 0);
    check("drain_wr", wr_q.size(), 0);
  endtask

  task automatic do_frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] dat);
    send_frame(cmd, adr, dat, -1);
    wait_idle();
  endtask

  logic [31:0] prog [5];
  logic [31:0] ra, rd;
  logic [7:0]  rc;
  int          nw;

  initial begin
    prog[0] = 32'h00010537;
    prog[1] = 32'h00052023;
    prog[2] = 32'h00052223;
    prog[3] = 32'h00052423;
    prog[4] = 32'h0000006f;

    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_n_reset", {31'd0, cpu_n_reset}, 32'd0);
    check("rst_mem_op", {31'd0, dbg_mem_op}, 32'd0);
    check("rst_wren", {28'd0, dbg_wren}, 32'd0);
    check("rst_adr", dbg_adr, 32'd0);
    check("rst_do", dbg_do, 32'd0);
    check("rst_tx", {23'd0, tx_valid, tx_data}, 32'd0);
    n_reset = 1'b1;
    @(posedge clk);
    #1;

    // Program load then release the CPU
    for (int i = 0; i < 5; i++) do_frame(CMD_WRITE, 32'h0002_0000 + 32'(4 * i), prog[i]);
    do_frame(CMD_GO, 32'd0, 32'd0);

    // Writes refused while running; halt again
    do_frame(CMD_WRITE, 32'h0002_0000, 32'hDEAD_BEEF);
    do_frame(CMD_HALT, 32'd0, 32'd0);

    // Misaligned address refused
    do_frame(CMD_WRITE, 32'h0002_0002, 32'h1234_5678);

    // Abandoned frame times out silently
    send_byte(CMD_WRITE, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (TMO + 1) begin
      @(posedge clk);
      #1;
    end
    check("timeout_no_rsp", {31'd0, tx_valid}, 32'd0);
    do_frame(CMD_WRITE, 32'h0000_1000, 32'hA5A5_5A5A);

    // Bytes landing exactly on the expiry cycle still count
    send_frame(CMD_WRITE, 32'h0000_2004, 32'h0BAD_CAFE, TMO - 1);
    wait_idle();

    // Redundant halt / go
    do_frame(CMD_HALT, 32'd0, 32'd0);
    do_frame(CMD_GO, 32'd0, 32'd0);
    do_frame(CMD_GO, 32'd0, 32'd0);
    do_frame(CMD_HALT, 32'd0, 32'd0);
    do_frame(8'hFF, 32'd0, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          ra = $urandom;
          if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
          rc = CMD_WRITE;
        end
        4:       rc = CMD_HALT;
        5:       rc = CMD_GO;
        default: rc = 8'($urandom);
      endcase
      rd = $urandom;
      do_frame(rc, ra, rd);
    end

    // Response held off by the transmitter; stray bytes must be dropped
    do_frame(CMD_HALT, 32'd0, 32'd0);
    hold_ready = 1'b1;
    send_frame(CMD_WRITE, 32'h0003_0000, 32'h7654_3210, 0);
    send_byte(CMD_GO, 0);
    send_byte(CMD_WRITE, 0);
    nw = 0;
    while (!tx_valid && nw < 20) begin
      @(posedge clk);
      #1;
      nw++;
    end
    check("hold_rsp_present", {31'd0, tx_valid}, 32'd1);
    send_byte(CMD_GO, 0);
    send_byte(CMD_HALT, 1);
    send_byte(CMD_WRITE, 0);
    repeat (50) begin
      @(posedge clk);
      #1;
    end
    check("hold_tx_valid", {31'd0, tx_valid}, 32'd1);
    check("hold_tx_data", {24'd0, tx_data}, {24'd0, RSP_ACK});
    check("hold_cpu", {31'd0, cpu_n_reset}, 32'd0);
    hold_ready = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of a write
    begin
      wr_t w;
      w.adr = 32'h0004_0000;
      w.dat = 32'hCAFE_F00D;
      wr_q.push_back(w);
    end
    send_byte(CMD_WRITE, 0);
    for (int i = 0; i < 4; i++) send_byte(8'(32'h0004_0000 >> (8 * i)), 0);
    for (int i = 0; i < 4; i++) send_byte(8'(32'hCAFE_F00D >> (8 * i)), 0);
    check("abort_op_started", {31'd0, dbg_mem_op}, 32'd1);
    #2;
    n_reset = 1'b0;
    #1;
    check("abort_mem_op", {31'd0, dbg_mem_op}, 32'd0);
    check("abort_wren", {28'd0, dbg_wren}, 32'd0);
    check("abort_adr", dbg_adr, 32'd0);
    check("abort_do", dbg_do, 32'd0);
    check("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("abort_cpu", {31'd0, cpu_n_reset}, 32'd0);
    wr_q.delete();
    rsp_q.delete();
    model_run = 1'b0;
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    @(posedge clk);
    #1;
    do_frame(CMD_WRITE, 32'h0004_0000, 32'h1111_2222);
    do_frame(CMD_GO, 32'd0, 32'd0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
